// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Free-running VGA timing generator. Horizontal and vertical counters
//   advance on each enabled pixel clock. All timing outputs are decoded from
//   the next counter values and registered, so hs/vs/blank/frame_start line
//   up with the DrawX/DrawY presented in the same cycle.
//
// Ports
//   vga_clk     : pixel clock, all logic on posedge
//   reset       : synchronous active-high reset, overrides enable
//   enable      : counters advance only when high
//   hs, vs      : horizontal / vertical sync, active low
//   blank       : high when the presented pixel is in the visible area
//   DrawX/DrawY : current horizontal / vertical count
//   frame_start : one-cycle pulse when (0,0) is entered after a frame wrap
//   frame_count : completed-frame counter, wraps at 16'hFFFF
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        enable,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       frame_wrap;

   always_comb begin
      x_next     = DrawX + 10'd1;
      y_next     = DrawY;
      frame_wrap = 1'b0;
      if (DrawX == H_LAST) begin
         x_next = '0;
         if (DrawY == V_LAST) begin
            y_next     = '0;
            frame_wrap = 1'b1;
         end else begin
            y_next = DrawY + 10'd1;
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         DrawX       <= '0;
         DrawY       <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank       <= 1'b1;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else if (enable) begin
         DrawX       <= x_next;
         DrawY       <= y_next;
         // decode from the next counts so outputs match the presented position
         hs          <= !((x_next >= HS_START) && (x_next < HS_END));
         vs          <= !((y_next >= VS_START) && (y_next < VS_END));
         blank       <= (x_next < H_VIS) && (y_next < V_VIS);
         frame_start <= frame_wrap;
         if (frame_wrap) begin
            frame_count <= frame_count + 16'd1;
         end
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Directed and random-enable stimulus for vga_sync_gen with a reduced
//   timing set so whole frames fit in a short run. The reference model
//   tracks a single linear pixel index within the frame and derives the
//   expected position and sync/blank levels arithmetically from it.
module tb_vga_sync_gen;

   localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
   localparam int VV = 10, VF = 2, VSW = 2, VB = 3;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int FRAME = HT * VT;
   localparam int HS0 = HV + HF;
   localparam int VS0 = VV + VF;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        hs, vs, blank, frame_start;
   logic [9:0]  DrawX, DrawY;
   logic [15:0] frame_count;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
   ) dut (
      .vga_clk(clk), .reset(rst), .enable(en),
      .hs(hs), .vs(vs), .blank(blank),
      .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_pos = 0;
   int m_fs  = 0;
   int m_fc  = 0;

   // statistics gathered over a window of ticks
   int hs_low, vs_low, blank_hi, fs_cnt, first_hs_x;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      hs_low = 0; vs_low = 0; blank_hi = 0; fs_cnt = 0; first_hs_x = -1;
   endtask

   task automatic check_model();
      int x, y;
      x = m_pos % HT;
      y = m_pos / HT;
      check("DrawX", 32'(DrawX), 32'(x));
      check("DrawY", 32'(DrawY), 32'(y));
      check("hs", 32'(hs), (x >= HS0 && x < HS0 + HSW) ? 32'd0 : 32'd1);
      check("vs", 32'(vs), (y >= VS0 && y < VS0 + VSW) ? 32'd0 : 32'd1);
      check("blank", 32'(blank), (x < HV && y < VV) ? 32'd1 : 32'd0);
      check("frame_start", 32'(frame_start), 32'(m_fs));
      check("frame_count", 32'(frame_count), 32'(m_fc));
   endtask

   task automatic tick(input logic e, input logic r);
      en  = e;
      rst = r;
      @(posedge clk);
      if (r) begin
         m_pos = 0; m_fs = 0; m_fc = 0;
      end else if (e) begin
         m_pos = (m_pos + 1) % FRAME;
         m_fs  = (m_pos == 0) ? 1 : 0;
         if (m_fs == 1) m_fc = (m_fc + 1) % 65536;
      end else begin
         m_fs = 0;
      end
      #1;
      check_model();
      if (hs == 1'b0) begin
         hs_low++;
         if (first_hs_x < 0) first_hs_x = int'(DrawX);
      end
      if (vs == 1'b0) vs_low++;
      if (blank == 1'b1) blank_hi++;
      if (frame_start == 1'b1) fs_cnt++;
   endtask

   initial begin
      int fs_at;
      en  = 1'b0;
      rst = 1'b1;
      clear_stats();

      // reset state
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);

      // one full line
      clear_stats();
      repeat (HT) tick(1'b1, 1'b0);
      check("line_hs_low_len", 32'(hs_low), 32'(HSW));
      check("line_hs_first_x", 32'(first_hs_x), 32'(HS0));
      check("line_end_x", 32'(DrawX), 32'd0);
      check("line_end_y", 32'(DrawY), 32'd1);

      // one full frame from reset
      tick(1'b1, 1'b1);
      clear_stats();
      fs_at = -1;
      for (int i = 1; i <= FRAME; i++) begin
         tick(1'b1, 1'b0);
         if (frame_start == 1'b1 && fs_at < 0) fs_at = i;
      end
      check("frame_fs_pulses", 32'(fs_cnt), 32'd1);
      check("frame_fs_cycle", 32'(fs_at), 32'(FRAME));
      check("frame_count_one", 32'(frame_count), 32'd1);
      check("frame_vs_low", 32'(vs_low), 32'(VSW * HT));
      check("frame_blank_hi", 32'(blank_hi), 32'(HV * VV));

      // enable held low at the last pixel of the frame
      tick(1'b1, 1'b1);
      repeat (FRAME - 1) tick(1'b1, 1'b0);
      check("hold_pre_x", 32'(DrawX), 32'(HT - 1));
      check("hold_pre_y", 32'(DrawY), 32'(VT - 1));
      clear_stats();
      repeat (5) tick(1'b0, 1'b0);
      check("hold_no_fs", 32'(fs_cnt), 32'd0);
      tick(1'b1, 1'b0);
      check("resume_fs", 32'(frame_start), 32'd1);
      check("resume_x", 32'(DrawX), 32'd0);
      check("resume_y", 32'(DrawY), 32'd0);

      // reset in the middle of both sync pulses
      tick(1'b1, 1'b1);
      repeat ((VS0 + 1) * HT + HS0 + 2) tick(1'b1, 1'b0);
      check("midsync_hs", 32'(hs), 32'd0);
      check("midsync_vs", 32'(vs), 32'd0);
      tick(1'b1, 1'b1);
      check("abort_x", 32'(DrawX), 32'd0);
      check("abort_y", 32'(DrawY), 32'd0);
      check("abort_hs", 32'(hs), 32'd1);
      check("abort_vs", 32'(vs), 32'd1);
      check("abort_blank", 32'(blank), 32'd1);
      check("abort_fc", 32'(frame_count), 32'd0);

      // random enable with occasional reset
      tick(1'b1, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
      end

      // frame counter wrap from a preloaded value
      tick(1'b1, 1'b1);
      force dut.frame_count = 16'hFFFF;
      release dut.frame_count;
      m_fc = 16'hFFFF;
      #1;
      check("preload_fc", 32'(frame_count), 32'hFFFF);
      repeat (FRAME) tick(1'b1, 1'b0);
      check("wrap_fs", 32'(frame_start), 32'd1);
      check("wrap_fc", 32'(frame_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
